uart_rx_deserializer: RTL and testbench

//  - Serial receiver for the UART. Samples the asynchronous RX pin and recovers
//    8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit.
//  - Presents each received byte on rx_data.
//  - Emits a one-cycle rx_done pulse that drives the S input of the

---
 rtl/uart_rx_deserializer_if.sv | 22 ++
 rtl/uart_rx_deserializer.sv | 133 +++++++++++++
 tb/tb_uart_rx_deserializer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deserializer_if.sv
// Output bundle of the UART receiver.
// Byte, done/error pulses and busy status toward the flag/consumer logic.
interface uart_rx_deserializer_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx_data,
        output rx_done,
        output frame_err,
        output busy
    );

    modport slave (
        input rx_data,
        input rx_done,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receiver: synchronises rx_in, recovers frames,
// pulses rx_done per good byte and frame_err on a low stop bit.
module uart_rx_deserializer #(
    parameter int BIT_CLKS = 2604
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_in,
    uart_rx_deserializer_if.master rx
);
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam logic [15:0] HALF_M1 = 16'(HALF_CLKS - 1);
    localparam logic [15:0] BIT_M1  = 16'(BIT_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t      state, state_n;
    logic        sync1, sync2;
    logic        rx_s;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic [7:0]  data_q, data_n;
    logic        done_q, done_n;
    logic        ferr_q, ferr_n;

    assign rx_s = sync2;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

    // State, counters, shift register and registered output pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= idx_n;
            shreg   <= shreg_n;
            data_q  <= data_n;
            done_q  <= done_n;
            ferr_q  <= ferr_n;
        end
    end

    // Next-state and datapath decisions; every sample point clears cnt.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = bit_idx;
        shreg_n = shreg;
        data_n  = data_q;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = 16'd0;
                if (!rx_s) begin
                    state_n = START;
                end
            end
            START: begin
                cnt_n = cnt + 16'd1;
                if (cnt == HALF_M1) begin
                    cnt_n = 16'd0;
                    idx_n = 3'd0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_n = cnt + 16'd1;
                if (cnt == BIT_M1) begin
                    cnt_n   = 16'd0;
                    shreg_n = {rx_s, shreg[7:1]};
                    idx_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                cnt_n = cnt + 16'd1;
                if (cnt == BIT_M1) begin
                    cnt_n = 16'd0;
                    if (rx_s) begin
                        data_n  = shreg;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BRK;
                    end
                end
            end
            BRK: begin
                cnt_n = 16'd0;
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 16'd0;
            end
        endcase
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_done   = done_q;
    assign rx.frame_err = ferr_q;
    assign rx.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed and random 8N1 frames,
// expectations queued at send time and checked by a pulse monitor.
module tb_uart_rx_deserializer;
    localparam int BIT = 16;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         fall;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx_in = 1'b1;

    uart_rx_deserializer_if ifc ();

    uart_rx_deserializer #(.BIT_CLKS(BIT)) dut (
        .clk   (clk),
        .reset (reset),
        .rx_in (rx_in),
        .rx    (ifc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];
    int done_cyc[$];
    int n_done = 0;
    int n_err = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output pulse.
    exp_t mon_e;
    int lat;
    bit prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (ifc.rx_done || ifc.frame_err) begin
            chk("pulse_exclusive", int'(ifc.rx_done & ifc.frame_err), 0);
            chk("pulse_not_consecutive", int'(prev_pulse), 0);
            if (ifc.rx_done) n_done++;
            if (ifc.frame_err) n_err++;
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind_is_err", int'(ifc.frame_err), int'(mon_e.err));
                chk("rx_data", int'(ifc.rx_data), int'(mon_e.data));
                lat = cyc - mon_e.fall;
                chk($sformatf("latency_152_156 lat=%0d", lat),
                    int'(lat >= 152 && lat <= 156), 1);
                if (ifc.rx_done) done_cyc.push_back(cyc);
            end
        end
        prev_pulse = ifc.rx_done | ifc.frame_err;
    end

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; leaves line at stop level after stop+extra clks.
    task automatic send_frame(input logic [7:0] d, input bit ok,
                              input int extra);
        exp_t e;
        rx_in = 1'b0;
        e.fall = cyc;
        e.err = !ok;
        e.data = ok ? d : last_good;
        if (ok) last_good = d;
        sb.push_back(e);
        repeat (BIT) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        rx_in = ok;
        repeat (BIT + extra) @(posedge clk);
        #1;
    endtask

    task automatic wait_busy_low(input string name, input int lim);
        for (int k = 0; k < lim && ifc.busy; k++) begin
            @(posedge clk);
            #1;
        end
        chk(name, int'(ifc.busy), 0);
    endtask

    int lows, c0, nd0, ne0;
    logic [7:0] pv, rd;
    bit ok;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset rx_data", int'(ifc.rx_data), 0);
        chk("reset rx_done", int'(ifc.rx_done), 0);
        chk("reset frame_err", int'(ifc.frame_err), 0);
        chk("reset busy", int'(ifc.busy), 0);
        reset = 1'b1;
        idle(10);

        // T1
        lows = 0;
        c0 = cyc;
        fork
            send_frame(8'h55, 1'b1, 0);
            for (int k = 0; k < 160; k++) begin
                @(negedge clk);
                if (cyc - c0 >= 4 && cyc - c0 <= 154 && !ifc.busy)
                    lows++;
            end
        join
        chk("T1 busy_low_cycles", lows, 0);
        chk("T1 rx_data", int'(ifc.rx_data), 8'h55);
        idle(20);

        // T2
        send_frame(8'hA3, 1'b1, 0);
        chk("T2 rx_data first", int'(ifc.rx_data), 8'hA3);
        send_frame(8'h0F, 1'b1, 0);
        chk("T2 rx_data second", int'(ifc.rx_data), 8'h0F);
        if (done_cyc.size() >= 2)
            chk("T2 spacing",
                done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2],
                160);
        else
            chk("T2 done_count", done_cyc.size(), 2);
        idle(20);

        // T3
        nd0 = n_done;
        ne0 = n_err;
        rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_in = 1'b1;
        wait_busy_low("T3 busy_drop", 10);
        idle(30);
        chk("T3 no_done", n_done - nd0, 0);
        chk("T3 no_err", n_err - ne0, 0);

        // T4
        pv = last_good;
        ne0 = n_err;
        send_frame(8'h3C, 1'b0, 384);
        chk("T4 busy_while_low", int'(ifc.busy), 1);
        chk("T4 rx_data_kept", int'(ifc.rx_data), int'(pv));
        rx_in = 1'b1;
        wait_busy_low("T4 busy_drop", 10);
        idle(10);
        chk("T4 one_frame_err", n_err - ne0, 1);

        // T5
        nd0 = n_done;
        rx_in = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (4 * BIT + BIT / 2) @(posedge clk);
        #1;
        reset = 1'b0;
        last_good = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("T5 reset rx_data", int'(ifc.rx_data), 0);
        chk("T5 reset busy", int'(ifc.busy), 0);
        reset = 1'b1;
        idle(20);
        chk("T5 rx_data_cleared", int'(ifc.rx_data), 0);
        fork
            send_frame(8'h81, 1'b1, 0);
            begin
                repeat (150) @(posedge clk);
                #1;
                chk("T5 rx_data_before_done", int'(ifc.rx_data), 0);
            end
        join
        chk("T5 one_done", n_done - nd0, 1);
        chk("T5 rx_data", int'(ifc.rx_data), 8'h81);
        idle(5);

        // T6
        ne0 = n_err;
        send_frame(8'h00, 1'b1, 0);
        chk("T6 rx_data zero", int'(ifc.rx_data), 8'h00);
        send_frame(8'hFF, 1'b1, 0);
        chk("T6 rx_data ones", int'(ifc.rx_data), 8'hFF);
        chk("T6 no_err", n_err - ne0, 0);
        idle(10);

        // Random frames, gaps and broken stop bits
        for (int n = 0; n < 24; n++) begin
            rd = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            if (ok) begin
                send_frame(rd, 1'b1, 0);
                idle($urandom_range(0, 25));
            end else begin
                send_frame(rd, 1'b0, $urandom_range(0, 40));
                rx_in = 1'b1;
                idle(5 + $urandom_range(0, 20));
            end
        end

        for (int k = 0; k < 400 && sb.size() != 0; k++)
            @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
